simple_bus: RTL and testbench
=============================

SIMPLE_BUS -- requirements
Module: simple_bus

Interface
- REQ-001 SHALL have parameter NrDevices, default 1: number of device ports (at least 1).
- REQ-002 SHALL have parameter NrHosts, default 1: number of host ports (at least 1).
- REQ-003 SHALL have parameter DataWidth, default 32: data bus width.
- REQ-004 SHALL have parameter AddressWidth, default 32: address bus width.
- REQ-005 SHALL have ports clk_i (in, 1) and rst_ni (in, 1); one clock; reset is asynchronous and active-low.
- REQ-006 SHALL have host_req_i (in, [NrHosts] x 1): host request.
- REQ-007 SHALL have host_gnt_o (out, [NrHosts] x 1): request granted.
- REQ-008 SHALL have host_addr_i (in, [NrHosts] x AddressWidth), host_we_i (in, [NrHosts] x 1), host_be_i (in, [NrHosts] x DataWidth/8) and host_wdata_i (in, [NrHosts] x DataWidth).
- REQ-009 SHALL have host_rvalid_o (out, [NrHosts] x 1), host_rdata_o (out, [NrHosts] x DataWidth) and host_err_o (out, [NrHosts] x 1): response to the host.
- REQ-010 SHALL have device_req_o, device_addr_o, device_we_o, device_be_o and device_wdata_o (out, [NrDevices] x matching width): request to the device.
- REQ-011 SHALL have device_rvalid_i, device_rdata_i and device_err_i (in, [NrDevices] x matching width): response from the device.
- REQ-012 SHALL have cfg_device_addr_base and cfg_device_addr_mask (in, [NrDevices] x AddressWidth): address map.
- REQ-013 All array ports SHALL be unpacked arrays indexed 0..N-1.

Function
- REQ-014 Arbitration SHALL be combinational fixed priority: the lowest-indexed host with host_req_i=1 is selected (host_sel); if no host requests, host_sel=0.
- REQ-015 Decode SHALL be combinational: device d matches when (host_addr_i[host_sel] & mask[d]) == base[d].
- REQ-016 If several devices match, the highest index SHALL win; if none match, the request SHALL route to device 0 (device_sel=0).
- REQ-017 host_gnt_o[h] SHALL be host_req_i[h] when h==host_sel, else 0, in the same cycle (zero-wait grant).
- REQ-018 device_req_o[d] SHALL be host_req_i[host_sel] when d==device_sel, else 0.
- REQ-019 device_addr/we/be/wdata_o[d] SHALL carry the selected host's fields when d==device_sel, else 0.
- REQ-020 host_sel and device_sel SHALL be registered every cycle, unconditionally, into host_sel_resp and device_sel_resp.
- REQ-021 host_rvalid_o[h], host_rdata_o[h] and host_err_o[h] SHALL equal device_rvalid_i, device_rdata_i and device_err_i of device_sel_resp when h==host_sel_resp, else 0.
- REQ-022 Devices SHALL be required to respond exactly one cycle after a granted request; request-to-response latency SHALL be 1 cycle.
- REQ-023 Back-to-back requests on consecutive cycles, including to different devices, SHALL be supported at full throughput.
- REQ-024 The bus SHALL have no outstanding-transaction tracking and no timeout.
- REQ-025 Simultaneous requests: only the winner SHALL get a grant; a losing host keeps requesting and is granted when it becomes highest priority.
- REQ-026 Selector widths SHALL be max(1, clog2(N)) bits.

Reset
- REQ-027 rst_ni low SHALL asynchronously clear host_sel_resp and device_sel_resp to 0.
- REQ-028 During reset the combinational paths SHALL stay active; host_rvalid_o[0] follows device_rvalid_i[0] and all other response outputs are 0.
- REQ-029 Reset asserted mid-transaction SHALL drop response routing to host 0/device 0 with no recovery state.

Verification
- REQ-030 Map: RAM base 0x100000 mask ~0xFFFFF, SimCtrl 0x20000 mask ~0x3FF, Timer 0x30000 mask ~0x3FF. Host 0 reads 0x100010 -> same cycle host_gnt_o[0]=1 and device_req_o[0]=1 with addr 0x100010; next cycle device_rvalid_i[0]=1 with rdata 0xDEADBEEF -> host_rvalid_o[0]=1 and host_rdata_o[0]=0xDEADBEEF.
- REQ-031 Host 0 writes 0x20000 with wdata 0x41, be 0xF -> device_req_o[1]=1, we=1, wdata 0x41; device_req_o[0]=device_req_o[2]=0 and their addr/wdata=0.
- REQ-032 Timer read at 0x30004 with device_err_i[2]=1 on the response cycle -> host_err_o[0]=1 one cycle after the grant.
- REQ-033 NrHosts=2, both request in the same cycle -> only host_gnt_o[0]=1; next cycle host 1 alone requests -> host_gnt_o[1]=1 and the response reaches host 1 only.
- REQ-034 Unmapped address 0x50000000 -> routed to device 0.
- REQ-035 Reset mid-read -> selector registers 0 immediately.
- REQ-036 Back-to-back reads to RAM then SimCtrl on consecutive cycles -> responses return in order with 1-cycle latency each.

Source files
------------

// File: rtl/simple_bus.sv
// Single-cycle shared bus: fixed-priority host arbitration, mask/base address decode,
// and response steering driven by the selectors registered on the request cycle.
module simple_bus #(
    parameter int unsigned NrDevices    = 1,
    parameter int unsigned NrHosts      = 1,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      host_req_i           [NrHosts],
    output logic                      host_gnt_o           [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i          [NrHosts],
    input  logic                      host_we_i            [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i            [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i         [NrHosts],
    output logic                      host_rvalid_o        [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o         [NrHosts],
    output logic                      host_err_o           [NrHosts],

    output logic                      device_req_o         [NrDevices],
    output logic [AddressWidth-1:0]   device_addr_o        [NrDevices],
    output logic                      device_we_o          [NrDevices],
    output logic [DataWidth/8-1:0]    device_be_o          [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o       [NrDevices],
    input  logic                      device_rvalid_i      [NrDevices],
    input  logic [DataWidth-1:0]      device_rdata_i       [NrDevices],
    input  logic                      device_err_i         [NrDevices],

    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

    localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

    logic [HostIdxW-1:0]     host_sel;
    logic [DevIdxW-1:0]      device_sel;
    logic [HostIdxW-1:0]     host_sel_resp;
    logic [DevIdxW-1:0]      device_sel_resp;

    logic                    sel_req;
    logic [AddressWidth-1:0] sel_addr;
    logic                    sel_we;
    logic [DataWidth/8-1:0]  sel_be;
    logic [DataWidth-1:0]    sel_wdata;

    logic                    resp_rvalid;
    logic [DataWidth-1:0]    resp_rdata;
    logic                    resp_err;

    // Descending scan so the lowest-indexed requester is the last one written.
    always_comb begin
        host_sel = '0;
        for (int h = NrHosts - 1; h >= 0; h--) begin
            if (host_req_i[h]) begin
                host_sel = HostIdxW'(h);
            end
        end
    end

    always_comb begin
        sel_req   = 1'b0;
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_be    = '0;
        sel_wdata = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (host_sel == HostIdxW'(h)) begin
                sel_req   = host_req_i[h];
                sel_addr  = host_addr_i[h];
                sel_we    = host_we_i[h];
                sel_be    = host_be_i[h];
                sel_wdata = host_wdata_i[h];
            end
        end
    end

    // Ascending scan: the highest matching device wins; no match falls back to device 0.
    always_comb begin
        device_sel = '0;
        for (int d = 0; d < NrDevices; d++) begin
            if ((sel_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                device_sel = DevIdxW'(d);
            end
        end
    end

    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_gnt_o[h] = (host_sel == HostIdxW'(h)) ? host_req_i[h] : 1'b0;
        end
    end

    always_comb begin
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = 1'b0;
            device_addr_o[d]  = '0;
            device_we_o[d]    = 1'b0;
            device_be_o[d]    = '0;
            device_wdata_o[d] = '0;
            if (device_sel == DevIdxW'(d)) begin
                device_req_o[d]   = sel_req;
                device_addr_o[d]  = sel_addr;
                device_we_o[d]    = sel_we;
                device_be_o[d]    = sel_be;
                device_wdata_o[d] = sel_wdata;
            end
        end
    end

    // Selectors are captured every cycle; a device answers exactly one cycle later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            host_sel_resp   <= '0;
            device_sel_resp <= '0;
        end else begin
            host_sel_resp   <= host_sel;
            device_sel_resp <= device_sel;
        end
    end

    always_comb begin
        resp_rvalid = 1'b0;
        resp_rdata  = '0;
        resp_err    = 1'b0;
        for (int d = 0; d < NrDevices; d++) begin
            if (device_sel_resp == DevIdxW'(d)) begin
                resp_rvalid = device_rvalid_i[d];
                resp_rdata  = device_rdata_i[d];
                resp_err    = device_err_i[d];
            end
        end
    end

    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_rvalid_o[h] = 1'b0;
            host_rdata_o[h]  = '0;
            host_err_o[h]    = 1'b0;
            if (host_sel_resp == HostIdxW'(h)) begin
                host_rvalid_o[h] = resp_rvalid;
                host_rdata_o[h]  = resp_rdata;
                host_err_o[h]    = resp_err;
            end
        end
    end

endmodule

// File: tb/tb_simple_bus.sv
// Directed bench for simple_bus with two hosts and a RAM / SimCtrl / Timer map.
module tb_simple_bus;

    localparam int NH = 2;
    localparam int ND = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni;

    logic        host_req     [NH];
    logic        host_gnt     [NH];
    logic [31:0] host_addr    [NH];
    logic        host_we      [NH];
    logic [3:0]  host_be      [NH];
    logic [31:0] host_wdata   [NH];
    logic        host_rvalid  [NH];
    logic [31:0] host_rdata   [NH];
    logic        host_err     [NH];

    logic        dev_req      [ND];
    logic [31:0] dev_addr     [ND];
    logic        dev_we       [ND];
    logic [3:0]  dev_be       [ND];
    logic [31:0] dev_wdata    [ND];
    logic        dev_rvalid   [ND];
    logic [31:0] dev_rdata    [ND];
    logic        dev_err      [ND];

    logic [31:0] cfg_base     [ND];
    logic [31:0] cfg_mask     [ND];

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    simple_bus #(
        .NrDevices    (ND),
        .NrHosts      (NH),
        .DataWidth    (32),
        .AddressWidth (32)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .host_req_i           (host_req),
        .host_gnt_o           (host_gnt),
        .host_addr_i          (host_addr),
        .host_we_i            (host_we),
        .host_be_i            (host_be),
        .host_wdata_i         (host_wdata),
        .host_rvalid_o        (host_rvalid),
        .host_rdata_o         (host_rdata),
        .host_err_o           (host_err),
        .device_req_o         (dev_req),
        .device_addr_o        (dev_addr),
        .device_we_o          (dev_we),
        .device_be_o          (dev_be),
        .device_wdata_o       (dev_wdata),
        .device_rvalid_i      (dev_rvalid),
        .device_rdata_i       (dev_rdata),
        .device_err_i         (dev_err),
        .cfg_device_addr_base (cfg_base),
        .cfg_device_addr_mask (cfg_mask)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_hosts();
        for (int h = 0; h < NH; h++) begin
            host_req[h]   = 1'b0;
            host_addr[h]  = '0;
            host_we[h]    = 1'b0;
            host_be[h]    = '0;
            host_wdata[h] = '0;
        end
    endtask

    task automatic clear_devs();
        for (int d = 0; d < ND; d++) begin
            dev_rvalid[d] = 1'b0;
            dev_rdata[d]  = '0;
            dev_err[d]    = 1'b0;
        end
    endtask

    task automatic host_read(input int h, input logic [31:0] a);
        host_req[h]  = 1'b1;
        host_addr[h] = a;
        host_we[h]   = 1'b0;
        host_be[h]   = 4'hF;
    endtask

    // Advance one clock and land on the following falling edge.
    task automatic next_cycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
        cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
        cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
        clear_hosts();
        clear_devs();
        rst_ni = 1'b0;

        // Reset: response routing pinned to host 0 / device 0
        dev_rvalid[0] = 1'b1;
        dev_rvalid[2] = 1'b1;
        #12;
        check("rst_rvalid0", 32'(host_rvalid[0]), 32'h1);
        check("rst_rvalid1", 32'(host_rvalid[1]), 32'h0);
        check("rst_gnt0",    32'(host_gnt[0]),    32'h0);
        clear_devs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        next_cycle();

        // RAM read with one-cycle response
        host_read(0, 32'h0010_0010);
        #1;
        check("ram_gnt0",   32'(host_gnt[0]), 32'h1);
        check("ram_gnt1",   32'(host_gnt[1]), 32'h0);
        check("ram_req0",   32'(dev_req[0]),  32'h1);
        check("ram_addr0",  dev_addr[0],      32'h0010_0010);
        check("ram_req1",   32'(dev_req[1]),  32'h0);
        next_cycle();
        clear_hosts();
        dev_rvalid[0] = 1'b1;
        dev_rdata[0]  = 32'hDEAD_BEEF;
        #1;
        check("ram_rvalid0", 32'(host_rvalid[0]), 32'h1);
        check("ram_rdata0",  host_rdata[0],       32'hDEAD_BEEF);
        check("ram_rvalid1", 32'(host_rvalid[1]), 32'h0);
        clear_devs();

        // SimCtrl write: only device 1 sees the fields
        host_req[0]   = 1'b1;
        host_addr[0]  = 32'h0002_0000;
        host_we[0]    = 1'b1;
        host_be[0]    = 4'hF;
        host_wdata[0] = 32'h41;
        #1;
        check("wr_req1",   32'(dev_req[1]), 32'h1);
        check("wr_we1",    32'(dev_we[1]),  32'h1);
        check("wr_wdata1", dev_wdata[1],    32'h41);
        check("wr_be1",    32'(dev_be[1]),  32'hF);
        check("wr_req0",   32'(dev_req[0]), 32'h0);
        check("wr_req2",   32'(dev_req[2]), 32'h0);
        check("wr_addr0",  dev_addr[0],     32'h0);
        check("wr_wdata0", dev_wdata[0],    32'h0);
        check("wr_addr2",  dev_addr[2],     32'h0);
        check("wr_wdata2", dev_wdata[2],    32'h0);
        next_cycle();
        clear_hosts();

        // Timer read returning an error
        host_read(0, 32'h0003_0004);
        #1;
        check("tmr_req2",  32'(dev_req[2]), 32'h1);
        check("tmr_addr2", dev_addr[2],     32'h0003_0004);
        check("tmr_err_early", 32'(host_err[0]), 32'h0);
        next_cycle();
        clear_hosts();
        dev_rvalid[2] = 1'b1;
        dev_err[2]    = 1'b1;
        dev_rdata[2]  = 32'h0000_1234;
        #1;
        check("tmr_err0",   32'(host_err[0]), 32'h1);
        check("tmr_rdata0", host_rdata[0],    32'h0000_1234);
        clear_devs();

        // Contention: host 0 wins, host 1 waits then gets its own response
        host_read(0, 32'h0010_0020);
        host_read(1, 32'h0002_0008);
        #1;
        check("arb_gnt0",  32'(host_gnt[0]), 32'h1);
        check("arb_gnt1",  32'(host_gnt[1]), 32'h0);
        check("arb_addr0", dev_addr[0],      32'h0010_0020);
        check("arb_req1",  32'(dev_req[1]),  32'h0);
        next_cycle();
        host_req[0]   = 1'b0;
        host_addr[0]  = '0;
        dev_rvalid[0] = 1'b1;
        dev_rdata[0]  = 32'h0000_AAAA;
        #1;
        check("arb_h0_rvalid", 32'(host_rvalid[0]), 32'h1);
        check("arb_h1_rvalid", 32'(host_rvalid[1]), 32'h0);
        check("arb2_gnt1",  32'(host_gnt[1]), 32'h1);
        check("arb2_gnt0",  32'(host_gnt[0]), 32'h0);
        check("arb2_req1",  32'(dev_req[1]),  32'h1);
        check("arb2_addr1", dev_addr[1],      32'h0002_0008);
        next_cycle();
        clear_hosts();
        clear_devs();
        dev_rvalid[1] = 1'b1;
        dev_rdata[1]  = 32'h0000_BBBB;
        #1;
        check("arb_h1_rvalid2", 32'(host_rvalid[1]), 32'h1);
        check("arb_h1_rdata2",  host_rdata[1],       32'h0000_BBBB);
        check("arb_h0_rvalid2", 32'(host_rvalid[0]), 32'h0);
        check("arb_h0_rdata2",  host_rdata[0],       32'h0);
        clear_devs();

        // Unmapped address falls back to device 0
        host_read(0, 32'h5000_0000);
        #1;
        check("unm_req0",  32'(dev_req[0]), 32'h1);
        check("unm_addr0", dev_addr[0],     32'h5000_0000);
        check("unm_req1",  32'(dev_req[1]), 32'h0);
        check("unm_req2",  32'(dev_req[2]), 32'h0);

        // Overlapping windows: highest matching index wins
        cfg_base[2] = 32'h0010_0000;
        cfg_mask[2] = ~32'h000F_FFFF;
        host_addr[0] = 32'h0010_0010;
        #1;
        check("ovl_req2", 32'(dev_req[2]), 32'h1);
        check("ovl_req0", 32'(dev_req[0]), 32'h0);
        cfg_base[2] = 32'h0003_0000;
        cfg_mask[2] = ~32'h0000_03FF;
        next_cycle();
        clear_hosts();
        next_cycle();

        // Back-to-back RAM then SimCtrl reads
        host_read(0, 32'h0010_0040);
        next_cycle();
        host_read(0, 32'h0002_0010);
        dev_rvalid[0] = 1'b1;
        dev_rdata[0]  = 32'h11;
        dev_rdata[1]  = 32'h66;
        #1;
        check("b2b_rvalid_a", 32'(host_rvalid[0]), 32'h1);
        check("b2b_rdata_a",  host_rdata[0],       32'h11);
        check("b2b_req1",     32'(dev_req[1]),     32'h1);
        next_cycle();
        clear_hosts();
        dev_rvalid[0] = 1'b0;
        dev_rdata[0]  = 32'h99;
        dev_rvalid[1] = 1'b1;
        dev_rdata[1]  = 32'h22;
        #1;
        check("b2b_rvalid_b", 32'(host_rvalid[0]), 32'h1);
        check("b2b_rdata_b",  host_rdata[0],       32'h22);
        clear_devs();

        // Reset mid-read drops routing back to host 0 / device 0
        host_read(1, 32'h0002_0000);
        next_cycle();
        clear_hosts();
        dev_rvalid[1] = 1'b1;
        dev_rdata[1]  = 32'h77;
        dev_rvalid[0] = 1'b1;
        dev_rdata[0]  = 32'h05;
        #1;
        check("mid_pre_rvalid1", 32'(host_rvalid[1]), 32'h1);
        check("mid_pre_rvalid0", 32'(host_rvalid[0]), 32'h0);
        rst_ni = 1'b0;
        #1;
        check("mid_rvalid1", 32'(host_rvalid[1]), 32'h0);
        check("mid_rdata1",  host_rdata[1],       32'h0);
        check("mid_rvalid0", 32'(host_rvalid[0]), 32'h1);
        check("mid_rdata0",  host_rdata[0],       32'h05);
        @(negedge clk_i);
        rst_ni = 1'b1;
        clear_devs();
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
